// File: rtl/ddr2_btm_local_arbiter.sv
// Two-port round-robin arbiter for the DDR2 controller local interface.
// Bounded same-port hold keeps row hits; a tag FIFO routes read data to its issuer.
module ddr2_btm_local_arbiter #(
  parameter int DATA_W   = 128,
  parameter int ROW_W    = 13,
  parameter int BANK_W   = 2,
  parameter int COL_W    = 9,
  parameter int HOLD     = 4,
  parameter int RD_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            p0_read_req,
  input  logic                            p0_write_req,
  input  logic [ROW_W+BANK_W+COL_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]               p0_wdata,
  input  logic [DATA_W/8-1:0]             p0_be,
  output logic                            p0_ready,
  output logic                            p0_rdata_valid,
  input  logic                            p1_read_req,
  input  logic                            p1_write_req,
  input  logic [ROW_W+BANK_W+COL_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]               p1_wdata,
  input  logic [DATA_W/8-1:0]             p1_be,
  output logic                            p1_ready,
  output logic                            p1_rdata_valid,
  output logic [DATA_W-1:0]               p_rdata,
  input  logic                            local_ready,
  input  logic                            local_init_done,
  input  logic                            local_rdata_valid,
  input  logic [DATA_W-1:0]               local_rdata,
  output logic                            local_read_req,
  output logic                            local_write_req,
  output logic                            local_burstbegin,
  output logic                            local_size,
  output logic [ROW_W-1:0]                local_row_addr,
  output logic [BANK_W-1:0]               local_bank_addr,
  output logic [COL_W-1:0]                local_col_addr,
  output logic [DATA_W-1:0]               local_wdata,
  output logic [DATA_W/8-1:0]             local_be,
  output logic                            err_orphan_rdata
);

  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RD_DEPTH + 1);
  localparam int HC_W   = $clog2(HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RD_DEPTH);

  // Handshake: a request is taken in the cycle where pN_*_req and pN_ready are
  // both high; the master must hold req/addr/wdata/be stable until then.
  // Controller commands are issued in that same cycle (zero latency).

  logic              owner;
  logic [HC_W-1:0]   hold_cnt;
  logic              tag_mem [RD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              req0, req1, sel, sel_req, sel_rd, owner_req;
  logic              rd_ok, go, push, pop, head;
  logic [ADDR_W-1:0] sel_addr;

  assign req0 = p0_read_req | p0_write_req;
  assign req1 = p1_read_req | p1_write_req;

  always_comb begin
    sel = 1'b0;
    if (req0 && !req1)
      sel = 1'b0;
    else if (req1 && !req0)
      sel = 1'b1;
    else if (req0 && req1)
      sel = (hold_cnt == HOLD_MAX) ? ~owner : owner;
  end

  assign sel_req   = sel ? req1 : req0;
  // Read wins over a simultaneous write on the same port.
  assign sel_rd    = sel ? p1_read_req : p0_read_req;
  assign owner_req = owner ? req1 : req0;
  // Registered count only: a pop in the same cycle does not free a slot.
  assign rd_ok     = (count != CNT_MAX);
  assign go        = sel_req & local_ready & local_init_done & (rd_ok | ~sel_rd);

  assign p0_ready         = go & ~sel;
  assign p1_ready         = go & sel;
  assign local_read_req   = go & sel_rd;
  assign local_write_req  = go & ~sel_rd;
  assign local_burstbegin = go;
  assign local_size       = 1'b1;

  assign sel_addr        = sel ? p1_addr : p0_addr;
  assign local_col_addr  = sel_addr[COL_W-1:0];
  assign local_bank_addr = sel_addr[COL_W +: BANK_W];
  assign local_row_addr  = sel_addr[COL_W+BANK_W +: ROW_W];
  assign local_wdata     = sel ? p1_wdata : p0_wdata;
  assign local_be        = sel ? p1_be : p0_be;

  assign push = local_read_req;
  assign pop  = local_rdata_valid & (count != '0);
  assign head = tag_mem[rd_ptr];

  assign p0_rdata_valid = pop & ~head;
  assign p1_rdata_valid = pop & head;
  assign p_rdata        = local_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      hold_cnt <= '0;
    end else if (go) begin
      owner    <= sel;
      hold_cnt <= (sel == owner) ? ((hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1)
                                 : HC_W'(1);
    end else if (local_init_done && !owner_req) begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      err_orphan_rdata <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (local_rdata_valid && count == '0) err_orphan_rdata <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr2_btm_local_arbiter.sv
// Directed and randomized bench for ddr2_btm_local_arbiter with a queue-based
// reference model of arbitration and read-tag ownership.
module tb_ddr2_btm_local_arbiter;
  localparam int DATA_W = 128, ROW_W = 13, BANK_W = 2, COL_W = 9, HOLD = 4, RD_DEPTH = 16;
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int BE_W   = DATA_W / 8;

  logic clk = 1'b0, reset = 1'b1;
  logic p0_read_req = 0, p0_write_req = 0, p1_read_req = 0, p1_write_req = 0;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0, local_rdata = '0;
  logic [BE_W-1:0]   p0_be = '0, p1_be = '0;
  logic local_ready = 1, local_init_done = 1, local_rdata_valid = 0;
  logic p0_ready, p1_ready, p0_rdata_valid, p1_rdata_valid;
  logic [DATA_W-1:0] p_rdata, local_wdata;
  logic local_read_req, local_write_req, local_burstbegin, local_size, err_orphan_rdata;
  logic [ROW_W-1:0]  local_row_addr;
  logic [BANK_W-1:0] local_bank_addr;
  logic [COL_W-1:0]  local_col_addr;
  logic [BE_W-1:0]   local_be;

  int checks = 0, errors = 0;

  ddr2_btm_local_arbiter #(.DATA_W(DATA_W), .ROW_W(ROW_W), .BANK_W(BANK_W), .COL_W(COL_W),
                           .HOLD(HOLD), .RD_DEPTH(RD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_ready(p0_ready), .p0_rdata_valid(p0_rdata_valid),
    .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_ready(p1_ready), .p1_rdata_valid(p1_rdata_valid),
    .p_rdata(p_rdata), .local_ready(local_ready), .local_init_done(local_init_done),
    .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_row_addr(local_row_addr), .local_bank_addr(local_bank_addr),
    .local_col_addr(local_col_addr), .local_wdata(local_wdata), .local_be(local_be),
    .err_orphan_rdata(err_orphan_rdata)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: owning port, consecutive-accept run, queue of read owners.
  bit m_owner, m_err;
  int m_hold;
  logic [0:0] exp_q[$];
  bit e_sel, e_go, e_rd, e_wr, e_rdy0, e_rdy1, e_vld0, e_vld1, e_oreq;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [BE_W-1:0]   e_be;

  function automatic void model_eval();
    bit q0, q1, srq, srd;
    q0 = p0_read_req || p0_write_req;
    q1 = p1_read_req || p1_write_req;
    e_sel = 0;
    if (q0 && !q1) e_sel = 0;
    else if (q1 && !q0) e_sel = 1;
    else if (q0 && q1) e_sel = (m_hold == HOLD) ? !m_owner : m_owner;
    srq  = e_sel ? q1 : q0;
    srd  = e_sel ? p1_read_req : p0_read_req;
    e_go = srq && local_ready && local_init_done && (exp_q.size() < RD_DEPTH || !srd);
    e_rd = e_go && srd;
    e_wr = e_go && !srd;
    e_rdy0 = e_go && !e_sel;
    e_rdy1 = e_go && e_sel;
    e_oreq = m_owner ? q1 : q0;
    e_vld0 = local_rdata_valid && exp_q.size() > 0 && exp_q[0] == 1'b0;
    e_vld1 = local_rdata_valid && exp_q.size() > 0 && exp_q[0] == 1'b1;
    e_addr  = e_sel ? p1_addr : p0_addr;
    e_wdata = e_sel ? p1_wdata : p0_wdata;
    e_be    = e_sel ? p1_be : p0_be;
  endfunction

  task automatic eval_cycle();
    #3;
    model_eval();
  endtask

  task automatic tick();
    if (reset) begin
      m_owner = 0; m_hold = 0; m_err = 0; exp_q.delete();
    end else begin
      if (local_rdata_valid) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1;
      end
      if (e_rd) exp_q.push_back(e_sel);
      if (e_go) begin
        m_hold  = (e_sel == m_owner) ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 1;
        m_owner = e_sel;
      end else if (local_init_done && !e_oreq) begin
        m_hold = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
    local_rdata_valid = 0; local_ready = 1; local_init_done = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    eval_cycle(); tick();
    eval_cycle(); tick();
    reset = 0;
  endtask

  // Driver helpers
  task automatic rand_port(input bit p);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    a = ADDR_W'($urandom);
    d = {$urandom, $urandom, $urandom, $urandom};
    if (p) begin p1_addr = a; p1_wdata = d; p1_be = BE_W'($urandom); end
    else   begin p0_addr = a; p0_wdata = d; p0_be = BE_W'($urandom); end
  endtask

  task automatic test_reset();
    do_reset();
    eval_cycle();
    checks++;
    if (err_orphan_rdata !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b exp 0", err_orphan_rdata);
    end
    checks++;
    if ({p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin} !== 5'b0) begin
      errors++; $display("FAIL reset_idle got %b exp 00000",
        {p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin});
    end
    checks++;
    if (local_size !== 1'b1) begin
      errors++; $display("FAIL local_size got %b exp 1", local_size);
    end
    tick();
    p0_write_req = 1; p1_write_req = 1;
    eval_cycle();
    checks++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_owner got p0=%b p1=%b exp p0=1 p1=0", p0_ready, p1_ready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_writes_p0();
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
    int wr_cycles = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      row = ROW_W'($urandom); bank = BANK_W'($urandom); col = COL_W'($urandom);
      rand_port(0);
      p0_addr = {row, bank, col};
      p0_write_req = 1;
      eval_cycle();
      if (local_write_req === 1'b1) wr_cycles++;
      checks++;
      if ({p0_ready, local_write_req, local_read_req, local_burstbegin} !== 4'b1101) begin
        errors++; $display("FAIL wr_p0_cmd beat %0d got %b exp 1101", i,
          {p0_ready, local_write_req, local_read_req, local_burstbegin});
      end
      checks++;
      if (local_row_addr !== row || local_bank_addr !== bank || local_col_addr !== col) begin
        errors++; $display("FAIL wr_p0_addr got %h/%h/%h exp %h/%h/%h",
          local_row_addr, local_bank_addr, local_col_addr, row, bank, col);
      end
      checks++;
      if (local_wdata !== p0_wdata || local_be !== p0_be) begin
        errors++; $display("FAIL wr_p0_data got %h/%h exp %h/%h", local_wdata, local_be, p0_wdata, p0_be);
      end
      tick();
    end
    checks++;
    if (wr_cycles != 8) begin
      errors++; $display("FAIL wr_p0_count got %0d exp 8", wr_cycles);
    end
    // Saturated hold hands the next contended grant to port 1.
    p1_write_req = 1; rand_port(1);
    eval_cycle();
    checks++;
    if ({p0_ready, p1_ready} !== 2'b01 || {e_rdy0, e_rdy1} !== 2'b01) begin
      errors++; $display("FAIL hold_saturate got p0=%b p1=%b exp p0=0 p1=1", p0_ready, p1_ready);
    end
    checks++;
    if (local_wdata !== p1_wdata) begin
      errors++; $display("FAIL hold_sat_wdata got %h exp %h", local_wdata, p1_wdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int run = 0, last = -1, g;
    do_reset();
    p0_write_req = 1; p1_write_req = 1;
    for (int i = 0; i < 20; i++) begin
      rand_port(0); rand_port(1);
      eval_cycle();
      g = p1_ready ? 1 : 0;
      checks++;
      if ((p0_ready ^ p1_ready) !== 1'b1 || g != (i / 4) % 2) begin
        errors++; $display("FAIL rr_grant cycle %0d got p0=%b p1=%b exp port %0d",
          i, p0_ready, p1_ready, (i / 4) % 2);
      end
      run = (g == last) ? run + 1 : 1;
      last = g;
      checks++;
      if (run > HOLD) begin
        errors++; $display("FAIL rr_starve run %0d exp <= %0d", run, HOLD);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_read_return();
    logic [DATA_W-1:0] d;
    bit exp_port [3];
    exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      rand_port(exp_port[i]);
      if (exp_port[i]) p1_read_req = 1; else p0_read_req = 1;
      eval_cycle();
      checks++;
      if (local_read_req !== 1'b1 || {p0_ready, p1_ready} !== (exp_port[i] ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rd_issue %0d got rd=%b p0=%b p1=%b", i, local_read_req, p0_ready, p1_ready);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin eval_cycle(); tick(); end
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      local_rdata = d; local_rdata_valid = 1;
      eval_cycle();
      checks++;
      if ({p0_rdata_valid, p1_rdata_valid} !== (exp_port[i] ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rd_return %0d got p0v=%b p1v=%b exp port %0d",
          i, p0_rdata_valid, p1_rdata_valid, exp_port[i]);
      end
      checks++;
      if (p_rdata !== d) begin
        errors++; $display("FAIL rd_data %0d got %h exp %h", i, p_rdata, d);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    p0_read_req = 1;
    for (int i = 0; i < RD_DEPTH; i++) begin rand_port(0); eval_cycle(); tick(); end
    // 17th read with a pop in the same cycle: still held.
    local_rdata_valid = 1;
    eval_cycle();
    checks++;
    if ({p0_ready, local_read_req, p0_rdata_valid} !== 3'b001) begin
      errors++; $display("FAIL full_hold got rdy=%b rd=%b v0=%b exp 0 0 1",
        p0_ready, local_read_req, p0_rdata_valid);
    end
    tick();
    local_rdata_valid = 0;
    eval_cycle();
    checks++;
    if ({p0_ready, local_read_req} !== 2'b11) begin
      errors++; $display("FAIL full_next got rdy=%b rd=%b exp 1 1", p0_ready, local_read_req);
    end
    tick();
    p1_write_req = 1; rand_port(1);
    eval_cycle();
    checks++;
    if ({p0_ready, p1_ready, local_write_req, local_read_req} !== 4'b0110) begin
      errors++; $display("FAIL full_write got %b exp 0110",
        {p0_ready, p1_ready, local_write_req, local_read_req});
    end
    tick();
    idle_inputs();
    local_rdata_valid = 1;
    for (int i = 0; i < RD_DEPTH; i++) begin
      eval_cycle();
      checks++;
      if ({p0_rdata_valid, p1_rdata_valid} !== 2'b10) begin
        errors++; $display("FAIL full_drain %0d got %b exp 10", i, {p0_rdata_valid, p1_rdata_valid});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_orphan();
    do_reset();
    local_rdata_valid = 1;
    eval_cycle();
    checks++;
    if ({p0_rdata_valid, p1_rdata_valid} !== 2'b00) begin
      errors++; $display("FAIL orphan_valid got %b exp 00", {p0_rdata_valid, p1_rdata_valid});
    end
    tick();
    local_rdata_valid = 0;
    eval_cycle();
    checks++;
    if (err_orphan_rdata !== 1'b1 || !m_err) begin
      errors++; $display("FAIL orphan_err got %b exp 1", err_orphan_rdata);
    end
    tick();
    do_reset();
    eval_cycle();
    checks++;
    if (err_orphan_rdata !== 1'b0) begin
      errors++; $display("FAIL orphan_clear got %b exp 0", err_orphan_rdata);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    p0_read_req = 1; p1_write_req = 1; rand_port(0); rand_port(1);
    for (int i = 0; i < 6; i++) begin
      local_init_done = (i >= 3); local_ready = (i < 3);
      eval_cycle();
      checks++;
      if ({p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin} !== 5'b0) begin
        errors++; $display("FAIL stall %0d got %b exp 00000", i,
          {p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin});
      end
      tick();
    end
    local_ready = 1;
    eval_cycle();
    checks++;
    if ({p0_ready, local_read_req} !== 2'b11) begin
      errors++; $display("FAIL stall_release got rdy=%b rd=%b exp 1 1", p0_ready, local_read_req);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    p0_read_req = 1; p1_read_req = 1;
    for (int i = 0; i < 6; i++) begin rand_port(0); rand_port(1); eval_cycle(); tick(); end
    reset = 1; eval_cycle(); tick(); reset = 0;
    eval_cycle();
    checks++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      errors++; $display("FAIL midreset_owner got p0=%b p1=%b exp 1 0", p0_ready, p1_ready);
    end
    tick();
    idle_inputs();
    eval_cycle(); tick();
    // Data for the flushed reads now arrives: one beat is owned by the post-reset read, the next is orphan.
    local_rdata_valid = 1;
    eval_cycle();
    checks++;
    if ({p0_rdata_valid, p1_rdata_valid} !== 2'b10) begin
      errors++; $display("FAIL midreset_first got %b exp 10", {p0_rdata_valid, p1_rdata_valid});
    end
    tick();
    eval_cycle();
    checks++;
    if ({p0_rdata_valid, p1_rdata_valid} !== 2'b00) begin
      errors++; $display("FAIL midreset_flushed got %b exp 00", {p0_rdata_valid, p1_rdata_valid});
    end
    tick();
    local_rdata_valid = 0;
    eval_cycle();
    checks++;
    if (err_orphan_rdata !== 1'b1) begin
      errors++; $display("FAIL midreset_err got %b exp 1", err_orphan_rdata);
    end
    tick();
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p0_read_req = ($urandom_range(0, 2) == 0); p0_write_req = ($urandom_range(0, 2) == 0);
      p1_read_req = ($urandom_range(0, 2) == 0); p1_write_req = ($urandom_range(0, 2) == 0);
      rand_port(0); rand_port(1);
      local_ready = ($urandom_range(0, 3) != 0);
      local_init_done = ($urandom_range(0, 9) != 0);
      local_rdata_valid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      local_rdata = {$urandom, $urandom, $urandom, $urandom};
      eval_cycle();
      checks++;
      if ({p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin,
           p0_rdata_valid, p1_rdata_valid, err_orphan_rdata} !==
          {e_rdy0, e_rdy1, e_rd, e_wr, e_go, e_vld0, e_vld1, m_err}) begin
        errors++; $display("FAIL rand_ctrl cycle %0d got %b exp %b", i,
          {p0_ready, p1_ready, local_read_req, local_write_req, local_burstbegin,
           p0_rdata_valid, p1_rdata_valid, err_orphan_rdata},
          {e_rdy0, e_rdy1, e_rd, e_wr, e_go, e_vld0, e_vld1, m_err});
      end
      checks++;
      if ({local_row_addr, local_bank_addr, local_col_addr} !== e_addr) begin
        errors++; $display("FAIL rand_addr cycle %0d got %h exp %h", i,
          {local_row_addr, local_bank_addr, local_col_addr}, e_addr);
      end
      checks++;
      if (local_wdata !== e_wdata || local_be !== e_be || p_rdata !== local_rdata) begin
        errors++; $display("FAIL rand_data cycle %0d got %h/%h exp %h/%h", i,
          local_wdata, local_be, e_wdata, e_be);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_writes_p0();
    test_round_robin();
    test_read_return();
    test_fifo_full();
    test_orphan();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
